tm_cpu_stall_model: RTL
=======================

# tm_cpu_stall_model

Parametrised per-thread CPU pipeline timing model. It consumes the functional-model (FM→TM) retire token stream and returns a TM→FM token stream. It holds each thread's run bit low for a configurable number of target cycles after a retired load, store or multiply. It sits between the CPU functional pipeline (regacc stage) and the DMA/debug controller, which starts and stops the model globally or per thread.

## Interface
Parameters:
- NTHREAD, 64: hardware thread count, power of two; TIDW = log2(NTHREAD).
- CNTW, 4: width of each per-thread stall counter.
- LD_LAT, 3: target cycles for a retired load (1..2^CNTW).
- ST_LAT, 2: target cycles for a retired store (1..2^CNTW).
- MUL_LAT, 4: target cycles for a retired umul/smul/umulcc/smulcc (1..2^CNTW).

Ports:
- gclk  in  1  clock.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  FM token valid.
- in_tid  in  TIDW  thread ID of the FM token.
- in_run  in  1  FM run bit.
- in_replay  in  1  FM replay bit.
- in_retired  in  1  FM retire flag.
- in_inst  in  32  retired SPARC instruction.
- ctrl  in  3  debug control: 0 nop, 1 start, 2 stop, 3 select_start, 4 select_stop; 5..7 are nop.
- ctrl_tid  in  TIDW  target thread for select_start and select_stop.
- threads_active  in  TIDW+1  number of modelled threads; tid ≥ threads_active is inactive.
- out_valid  out  1  TM token valid.
- out_tid  out  TIDW  echoed thread ID.
- out_run  out  1  thread may issue.
- running  out  1  global model run state.
- stall_cnt  out  32  count of tokens returned with run=0 while running; wraps.

## Operation
- State: global `running`; per-thread enable en[NTHREAD]; per-thread counter cnt[NTHREAD] of CNTW bits. Counters are a register array or distributed RAM with read-modify-write on in_tid.
- Control:
  - start sets running.
  - stop clears running.
  - select_start sets en[ctrl_tid]; select_stop clears en[ctrl_tid].
  - Control has no effect on counters.
- Token processing, for each in_valid token with tid t:
  - eligible = running & en[t] & (t < threads_active).
  - If !running: out_run = 0 and cnt[t] is unchanged (frozen).
  - Else if cnt[t] != 0: out_run = 0 and cnt[t] decrements by 1.
  - Else: out_run = eligible. If in_retired & in_run & ~in_replay, cnt[t] loads (class latency − 1).
- Instruction classification:
  - Load: inst[31:30]=11 and inst[21]=0.
  - Store: inst[31:30]=11 and inst[21]=1.
  - Multiply: inst[31:30]=10, inst[24]=0, inst[22:20]=101.
  - Anything else: latency 1, so cnt stays 0.
- stall_cnt increments when a token is returned with out_run=0 and running=1 at that token, regardless of en. It wraps at 2^32.
- Replay tokens never load a counter. An in_valid token for an inactive thread (t ≥ threads_active) still returns a token with out_run=0 and still updates cnt normally.

## Timing
- Reset values:
  - out_valid=0, out_tid=0, out_run=0, running=0, stall_cnt=0.
  - All en=1 and all cnt=0. For a RAM implementation, this requires a reset sweep of NTHREAD cycles. During the sweep, in_valid tokens are answered with out_run=0 and no counter update.
- Latency: exactly 1 cycle. A token at edge N produces out_valid/out_tid/out_run at edge N+1. One token is accepted per cycle with no backpressure.
- in_valid=0 gives out_valid=0 the next cycle. out_tid and out_run hold their last values.
- Control is registered. ctrl at edge N first affects tokens sampled at edge N+1. A token arriving in the same cycle as start or stop sees the old running.
- Back-to-back tokens for the same tid in consecutive cycles must see the updated cnt (bypass the read-modify-write).
- The cnt decrement saturates at 0 and never wraps.
- Async reset mid-stream: all outputs clear immediately. The token in flight is dropped.

## Test plan
- Reset, then start, then tokens for tids 0..3 with non-memory insts, round-robin → out_run=1 for each, 1 cycle later, stall_cnt=0.
- Thread 2 retires a load (inst=0xC2000000), LD_LAT=3 → the next two thread-2 tokens return run=0 and the third returns run=1; stall_cnt=2.
- Thread 1 retires umul (inst=0x82504001) with in_replay=1 → no stall; with in_replay=0 → 3 tokens with run=0.
- select_stop on tid 5, then a tid 5 token → run=0 and stall_cnt increments. select_start on tid 5 → the next tid 5 token returns run=1.
- Issue stop while tid 0 has cnt=2 → tokens return run=0 and stall_cnt is frozen. Issue start → 2 more run=0 tokens, then run=1.
- threads_active=2, then a tid 3 token → run=0. Then assert async reset mid-stream → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/tm_cpu_stall_model_if.sv
// Token bus between the CPU functional model (master) and the stall timing model (slave).
// Carries the FM->TM retire token and the 1-cycle-later TM->FM run token.
interface tm_cpu_stall_model_if #(
  parameter int NTHREAD = 64
);
  localparam int TIDW = $clog2(NTHREAD);

  logic            in_valid;
  logic [TIDW-1:0] in_tid;
  logic            in_run;
  logic            in_replay;
  logic            in_retired;
  logic [31:0]     in_inst;

  logic            out_valid;
  logic [TIDW-1:0] out_tid;
  logic            out_run;

  modport master (
    output in_valid, in_tid, in_run, in_replay, in_retired, in_inst,
    input  out_valid, out_tid, out_run
  );

  modport slave (
    input  in_valid, in_tid, in_run, in_replay, in_retired, in_inst,
    output out_valid, out_tid, out_run
  );
endinterface

// File: rtl/tm_cpu_stall_model.sv
// Per-thread CPU timing model: holds a thread's run bit low for a class-dependent number of
// tokens after a retired load/store/multiply. One token per cycle, 1-cycle latency, no backpressure.
module tm_cpu_stall_model #(
  parameter int NTHREAD = 64,
  parameter int CNTW    = 4,
  parameter int LD_LAT  = 3,
  parameter int ST_LAT  = 2,
  parameter int MUL_LAT = 4,
  parameter int TIDW    = $clog2(NTHREAD)
) (
  input  logic                gclk,
  input  logic                rst,
  tm_cpu_stall_model_if.slave bus,
  input  logic [2:0]          ctrl,
  input  logic [TIDW-1:0]     ctrl_tid,
  input  logic [TIDW:0]       threads_active,
  output logic                running,
  output logic [31:0]         stall_cnt
);

  localparam logic [2:0] CTRL_START     = 3'd1;
  localparam logic [2:0] CTRL_STOP      = 3'd2;
  localparam logic [2:0] CTRL_SEL_START = 3'd3;
  localparam logic [2:0] CTRL_SEL_STOP  = 3'd4;

  // Counter holds the number of further stalled tokens, i.e. latency minus one.
  localparam logic [CNTW-1:0] LD_LOAD  = CNTW'(LD_LAT - 1);
  localparam logic [CNTW-1:0] ST_LOAD  = CNTW'(ST_LAT - 1);
  localparam logic [CNTW-1:0] MUL_LOAD = CNTW'(MUL_LAT - 1);

  logic                running_q, running_d;
  logic [NTHREAD-1:0]  en_q, en_d;
  logic [CNTW-1:0]     cnt_q [NTHREAD];
  logic [CNTW-1:0]     cnt_d [NTHREAD];
  logic                out_valid_q, out_valid_d;
  logic [TIDW-1:0]     out_tid_q, out_tid_d;
  logic                out_run_q, out_run_d;
  logic [31:0]         stall_cnt_q, stall_cnt_d;

  logic [CNTW-1:0]     cur_cnt;
  logic                is_load, is_store, is_mul;
  logic [CNTW-1:0]     load_val;
  logic                tid_active;
  logic                eligible;
  logic                tok_run;
  logic                cnt_we;
  logic [CNTW-1:0]     cnt_wval;
  logic                unused_inst_bits;

  assign unused_inst_bits = ^{bus.in_inst[29:25], bus.in_inst[23], bus.in_inst[19:0]};

  // Instruction class decode
  always_comb begin
    is_load  = (bus.in_inst[31:30] == 2'b11) && !bus.in_inst[21];
    is_store = (bus.in_inst[31:30] == 2'b11) &&  bus.in_inst[21];
    is_mul   = (bus.in_inst[31:30] == 2'b10) && !bus.in_inst[24] &&
               (bus.in_inst[22:20] == 3'b101);
    load_val = '0;
    if (is_load) begin
      load_val = LD_LOAD;
    end else if (is_store) begin
      load_val = ST_LOAD;
    end else if (is_mul) begin
      load_val = MUL_LOAD;
    end
  end

  // Token evaluation; counters are flops, so the next token always reads the updated value.
  always_comb begin
    cur_cnt    = cnt_q[bus.in_tid];
    tid_active = ({1'b0, bus.in_tid} < threads_active);
    eligible   = running_q && en_q[bus.in_tid] && tid_active;
    tok_run    = 1'b0;
    cnt_we     = 1'b0;
    cnt_wval   = cur_cnt;
    if (bus.in_valid && running_q) begin
      if (cur_cnt != '0) begin
        cnt_we   = 1'b1;
        cnt_wval = cur_cnt - CNTW'(1);
      end else begin
        tok_run = eligible;
        if (bus.in_retired && bus.in_run && !bus.in_replay) begin
          cnt_we   = 1'b1;
          cnt_wval = load_val;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_we) begin
      cnt_d[bus.in_tid] = cnt_wval;
    end
  end

  // Control takes effect for tokens sampled on the following edge.
  always_comb begin
    running_d = running_q;
    en_d      = en_q;
    case (ctrl)
      CTRL_START:     running_d = 1'b1;
      CTRL_STOP:      running_d = 1'b0;
      CTRL_SEL_START: en_d[ctrl_tid] = 1'b1;
      CTRL_SEL_STOP:  en_d[ctrl_tid] = 1'b0;
      default:        ;
    endcase
  end

  always_comb begin
    out_valid_d = bus.in_valid;
    out_tid_d   = out_tid_q;
    out_run_d   = out_run_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.in_valid) begin
      out_tid_d = bus.in_tid;
      out_run_d = tok_run;
      if (running_q && !tok_run) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      running_q   <= 1'b0;
      en_q        <= '1;
      out_valid_q <= 1'b0;
      out_tid_q   <= '0;
      out_run_q   <= 1'b0;
      stall_cnt_q <= '0;
      for (int i = 0; i < NTHREAD; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      running_q   <= running_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
      out_tid_q   <= out_tid_d;
      out_run_q   <= out_run_d;
      stall_cnt_q <= stall_cnt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_tid   = out_tid_q;
  assign bus.out_run   = out_run_q;
  assign running       = running_q;
  assign stall_cnt     = stall_cnt_q;

endmodule
